// File: rtl/split_bus_arbiter.sv
// Bus arbiter for two initiators and one split-capable target: grants, split
// parking/lending, starvation override for initiator 2 and hold timeout.
module split_bus_arbiter #(
  parameter int STARVE_LIMIT = 16,
  parameter int HOLD_LIMIT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       split_s_req,
  input  logic       xfer_done,
  input  logic       split_start,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       split_s_grant,
  output logic [1:0] bus_owner,
  output logic       split_pending,
  output logic       split_owner,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    G_M1    = 2'd1,
    G_M2    = 2'd2,
    G_SPLIT = 2'd3
  } state_t;

  localparam logic [7:0]  STARVE_TH = 8'(STARVE_LIMIT);
  localparam logic [15:0] HOLD_MAX  = 16'(HOLD_LIMIT - 1);

  state_t      state_r;
  state_t      state_s;
  logic        pend_s;
  logic        owner_s;
  logic        tmo_s;
  logic [7:0]  starve_r;
  logic [7:0]  starve_s;
  logic [15:0] hold_r;
  logic [15:0] hold_s;
  logic        eff_m1_s;
  logic        eff_m2_s;
  logic        hold_expired_s;

  // The parked initiator may not compete until its split data has returned.
  assign eff_m1_s       = m1_req & ~(split_pending & ~split_owner);
  assign eff_m2_s       = m2_req & ~(split_pending & split_owner);
  assign hold_expired_s = (hold_r == HOLD_MAX);

  // Next-state, split bookkeeping and timeout decision.
  always_comb begin
    state_s = state_r;
    pend_s  = split_pending;
    owner_s = split_owner;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (split_s_req && split_pending) begin
          state_s = G_SPLIT;
        end else if (eff_m2_s && (starve_r >= STARVE_TH)) begin
          state_s = G_M2;
        end else if (eff_m1_s) begin
          state_s = G_M1;
        end else if (eff_m2_s) begin
          state_s = G_M2;
        end else begin
          state_s = IDLE;
        end
      end
      G_M1, G_M2: begin
        if (split_start) begin
          state_s = IDLE;
          // A second split while one is outstanding just ends the transfer.
          if (!split_pending) begin
            pend_s  = 1'b1;
            owner_s = (state_r == G_M2);
          end else begin
            pend_s  = split_pending;
          end
        end else if (xfer_done) begin
          state_s = IDLE;
        end else if (hold_expired_s) begin
          state_s = IDLE;
          tmo_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      G_SPLIT: begin
        if (xfer_done) begin
          state_s = IDLE;
          pend_s  = 1'b0;
        end else if (hold_expired_s) begin
          state_s = IDLE;
          pend_s  = 1'b0;
          tmo_s   = 1'b1;
        end else begin
          state_s = G_SPLIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Starvation and hold counters.
  always_comb begin
    starve_s = starve_r;
    hold_s   = hold_r;
    if ((state_s == G_M2) && (state_r != G_M2)) begin
      starve_s = 8'd0;
    end else if (!eff_m2_s) begin
      starve_s = 8'd0;
    end else if ((state_r != G_M2) && (starve_r != 8'hFF)) begin
      starve_s = starve_r + 8'd1;
    end else begin
      starve_s = starve_r;
    end
    if ((state_s != state_r) || (state_r == IDLE)) begin
      hold_s = 16'd0;
    end else begin
      hold_s = hold_r + 16'd1;
    end
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      starve_r      <= 8'd0;
      hold_r        <= 16'd0;
      split_pending <= 1'b0;
      split_owner   <= 1'b0;
      timeout_err   <= 1'b0;
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      split_s_grant <= 1'b0;
      bus_owner     <= 2'd0;
    end else begin
      state_r       <= state_s;
      starve_r      <= starve_s;
      hold_r        <= hold_s;
      split_pending <= pend_s;
      split_owner   <= owner_s;
      timeout_err   <= tmo_s;
      m1_grant      <= (state_s == G_M1);
      m2_grant      <= (state_s == G_M2);
      split_s_grant <= (state_s == G_SPLIT);
      bus_owner     <= state_s;
    end
  end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed testbench for split_bus_arbiter with small starvation/hold limits.
module tb_split_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m1_req, m2_req, split_s_req, xfer_done, split_start;
  logic       m1_grant, m2_grant, split_s_grant;
  logic [1:0] bus_owner;
  logic       split_pending, split_owner, timeout_err;

  int total  = 0;
  int passed = 0;

  split_bus_arbiter #(.STARVE_LIMIT(4), .HOLD_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m1_req(m1_req), .m2_req(m2_req), .split_s_req(split_s_req),
    .xfer_done(xfer_done), .split_start(split_start),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .split_s_grant(split_s_grant),
    .bus_owner(bus_owner), .split_pending(split_pending),
    .split_owner(split_owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // grants packed as {split_s, m2, m1}
  task automatic chk_bus(input string tag, input logic [2:0] g, input logic [1:0] own);
    chk({tag, "_grants"}, {13'd0, split_s_grant, m2_grant, m1_grant}, {13'd0, g});
    chk({tag, "_owner"}, {14'd0, bus_owner}, {14'd0, own});
  endtask

  initial begin
    rst_n = 1'b0;
    m1_req = 1'b1; m2_req = 1'b1;
    split_s_req = 1'b0; xfer_done = 1'b0; split_start = 1'b0;
    #2;
    chk_bus("reset", 3'b000, 2'd0);
    chk("reset_pend", {15'd0, split_pending}, 16'd0);
    chk("reset_tmo", {15'd0, timeout_err}, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;

    // simultaneous requests: m1 first, then m2 after one idle cycle
    tick();
    chk_bus("simul_m1", 3'b001, 2'd1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk_bus("simul_idle", 3'b000, 2'd0);
    m1_req = 1'b0;
    tick();
    chk_bus("simul_m2", 3'b010, 2'd2);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    m2_req = 1'b0; m1_req = 1'b1;

    // split lending
    tick();
    chk_bus("split_m1", 3'b001, 2'd1);
    split_start = 1'b1;
    tick();
    split_start = 1'b0;
    chk_bus("split_idle", 3'b000, 2'd0);
    chk("split_pend_set", {15'd0, split_pending}, 16'd1);
    chk("split_owner_m1", {15'd0, split_owner}, 16'd0);
    m2_req = 1'b1;
    tick();
    chk_bus("lend_m2", 3'b010, 2'd2);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk_bus("lend_done", 3'b000, 2'd0);
    chk("lend_pend_held", {15'd0, split_pending}, 16'd1);
    m2_req = 1'b0; split_s_req = 1'b1;
    tick();
    chk_bus("split_return", 3'b100, 2'd3);
    xfer_done = 1'b1; m1_req = 1'b0;
    tick();
    xfer_done = 1'b0; split_s_req = 1'b0;
    chk_bus("split_end", 3'b000, 2'd0);
    chk("split_pend_clr", {15'd0, split_pending}, 16'd0);
    tick();
    chk_bus("split_stay_idle", 3'b000, 2'd0);

    // starvation override at STARVE_LIMIT = 4
    m1_req = 1'b1; m2_req = 1'b1;
    tick();
    chk_bus("starve_m1a", 3'b001, 2'd1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    tick();
    chk_bus("starve_m1b", 3'b001, 2'd1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("starve_cnt4", {8'd0, dut.starve_r}, 16'd4);
    tick();
    chk_bus("starve_m2", 3'b010, 2'd2);
    chk("starve_cnt0", {8'd0, dut.starve_r}, 16'd0);
    xfer_done = 1'b1; m1_req = 1'b0; m2_req = 1'b0;
    tick();
    xfer_done = 1'b0;

    // hold timeout at HOLD_LIMIT = 8
    m1_req = 1'b1;
    tick();
    m1_req = 1'b0;
    chk_bus("hold_g0", 3'b001, 2'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("hold_grant", {15'd0, m1_grant}, 16'd1);
      chk("hold_no_tmo", {15'd0, timeout_err}, 16'd0);
    end
    tick();
    chk_bus("hold_release", 3'b000, 2'd0);
    chk("hold_tmo_pulse", {15'd0, timeout_err}, 16'd1);
    chk("hold_no_pend", {15'd0, split_pending}, 16'd0);
    tick();
    chk("hold_tmo_end", {15'd0, timeout_err}, 16'd0);

    // split_start and xfer_done together in G_M2
    m2_req = 1'b1;
    tick();
    m2_req = 1'b0;
    chk_bus("both_m2", 3'b010, 2'd2);
    split_start = 1'b1; xfer_done = 1'b1;
    tick();
    split_start = 1'b0; xfer_done = 1'b0;
    chk("both_pend", {15'd0, split_pending}, 16'd1);
    chk("both_owner", {15'd0, split_owner}, 16'd1);
    m2_req = 1'b1;
    tick();
    tick();
    chk_bus("mask_m2", 3'b000, 2'd0);
    m2_req = 1'b0;

    // second split from the non-parked initiator only ends its transfer
    m1_req = 1'b1;
    tick();
    m1_req = 1'b0;
    chk_bus("second_m1", 3'b001, 2'd1);
    split_start = 1'b1;
    tick();
    split_start = 1'b0;
    chk_bus("second_idle", 3'b000, 2'd0);
    chk("second_pend", {15'd0, split_pending}, 16'd1);
    chk("second_owner", {15'd0, split_owner}, 16'd1);

    // reset in G_SPLIT
    split_s_req = 1'b1;
    tick();
    chk_bus("rst_split", 3'b100, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bus("rst_async", 3'b000, 2'd0);
    chk("rst_pend", {15'd0, split_pending}, 16'd0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk_bus("rst_no_split", 3'b000, 2'd0);
    split_s_req = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/split_bus_arbiter.md
# split_bus_arbiter

Registered arbiter and transaction sequencer for the two-initiator system bus with one split-capable target, the bus-bridge slave. It owns the grant lines for initiator 1, initiator 2 and the split target's re-arbitration request. It parks an initiator whose transaction was split and lends the bus to the other initiator meanwhile. It returns the bus to the split target when the bridge has the response ready, and breaks hung transactions with a hold timeout.

## Interface
Parameters:
- STARVE_LIMIT, 16: consecutive cycles initiator 2 may wait before it overrides initiator 1's priority (1..255).
- HOLD_LIMIT, 1024: maximum cycles in any grant state without completion before a forced release (1..65535).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m1_req  in  1  initiator 1 bus request, level.
- m2_req  in  1  initiator 2 bus request, level.
- split_s_req  in  1  split target requests the bus to return split data, level.
- xfer_done  in  1  single-cycle pulse: current transaction completed (target ack or read data accepted).
- split_start  in  1  single-cycle pulse: addressed target answered with split ack.
- m1_grant  out  1  initiator 1 owns the bus.
- m2_grant  out  1  initiator 2 owns the bus.
- split_s_grant  out  1  split target owns the bus for its response.
- bus_owner  out  2  0 none, 1 m1, 2 m2, 3 split target.
- split_pending  out  1  a split transaction is outstanding.
- split_owner  out  1  parked initiator: 0 = m1, 1 = m2; valid while split_pending is high.
- timeout_err  out  1  single-cycle pulse on a forced release.

## Operation
- States: IDLE, G_M1, G_M2, G_SPLIT. Outputs are decoded from registered state, so they carry no combinational path from the requests.
- Request masking: while split_pending is high, the request of the initiator named by split_owner is masked.
- IDLE selection, in priority order:
  1. split_s_req && split_pending → G_SPLIT.
  2. Effective m2_req && starve_cnt >= STARVE_LIMIT → G_M2.
  3. Effective m1_req → G_M1.
  4. Effective m2_req → G_M2.
  5. Otherwise stay in IDLE.
- G_M1 / G_M2:
  - split_start → IDLE; set split_pending; split_owner = current initiator.
  - Otherwise xfer_done → IDLE.
  - split_start wins when both pulse in the same cycle.
- G_SPLIT:
  - xfer_done → IDLE; clear split_pending.
  - split_start is ignored here.
- split_s_req while split_pending is low is ignored. split_start is ignored in IDLE.
- While split_pending is high, a second split_start from the non-parked initiator is treated as xfer_done. Only one split is outstanding at a time.
- starve_cnt (8 bits, saturating at 255):
  - Increments each cycle the effective m2_req is high and the state is not G_M2.
  - Clears on entry to G_M2 and whenever the effective m2_req is low.
- hold_cnt (16 bits):
  - Clears on every entry to a grant state and increments each cycle while in that state.
  - When it reaches HOLD_LIMIT-1 without xfer_done or split_start, the arbiter goes to IDLE and pulses timeout_err.
  - A timeout in G_SPLIT also clears split_pending.
  - A timeout never sets split_pending.
- Reset: state IDLE; all grants 0; bus_owner 0; split_pending 0; split_owner 0; timeout_err 0; both counters 0. A reset mid-transaction drops grants immediately and asynchronously, and discards any outstanding split.

## Timing
- Request-to-grant: a request seen in IDLE at edge N gives a grant high after edge N+1, i.e. 1 cycle latency.
- Grant release: the grant falls in the cycle after xfer_done or split_start.
- Bus turnaround: at least one IDLE cycle separates any two grants.
- Initiator back-to-back: consecutive grants to the same initiator are 2 cycles apart at minimum.
- Exclusivity: at most one of the three grants is high in any cycle; bus_owner always matches it.
- split_pending rises with the cycle following split_start and falls in the cycle following xfer_done in G_SPLIT.
- timeout_err: exactly 1 cycle, coincident with the first IDLE cycle after the forced release.

## Test plan
- Simultaneous requests: m1_req = m2_req = 1 from reset → m1_grant at cycle 2. xfer_done → IDLE, then m2_grant two cycles after xfer_done.
- Split lending:
  - In G_M1, pulse split_start → split_pending = 1, split_owner = 0.
  - With m1_req held high, m2_req = 1 → m2_grant, with no m1_grant during the split.
  - After m2's xfer_done, raise split_s_req → split_s_grant, bus_owner = 3.
  - xfer_done → split_pending = 0.
- Starvation override: STARVE_LIMIT = 4, m1_req held high with repeated 1-cycle transactions, m2_req = 1 → m2 is granted once starve_cnt reaches 4, then starve_cnt reads 0.
- Hold timeout: HOLD_LIMIT = 8, grant m1 and never pulse xfer_done → m1_grant drops after 8 grant cycles; timeout_err pulses once.
- Simultaneous events: split_start and xfer_done together in G_M2 → split_pending = 1, split_owner = 1.
- Reset mid-operation: assert rst_n = 0 in G_SPLIT → all grants low immediately. After release with split_s_req = 1, no split_s_grant occurs.
